// File: rtl/axis_gap_pkg.sv
// Shared types and helpers for the AXI-Stream inter-packet gap checker.
package axis_gap_pkg;

  typedef enum logic [1:0] {
    ST_START,
    ST_GAP,
    ST_PKT,
    ST_DROP
  } gap_state_e;

  // All-ones value for a counter of the given width (width 1..63).
  function automatic logic [63:0] gap_sat(input int width);
    return ~64'd0 >> (64 - width);
  endfunction

endpackage

// File: rtl/axis_gap_stats.sv
// Gap statistics for debug registers: last gap, minimum gap and saturating violation count.
module axis_gap_stats
  import axis_gap_pkg::*;
#(
  parameter int GAP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 update,
  input  logic [GAP_WIDTH-1:0] gap,
  input  logic                 viol,
  input  logic                 clear,
  output logic                 gap_violation,
  output logic [GAP_WIDTH-1:0] last_gap,
  output logic [GAP_WIDTH-1:0] min_gap,
  output logic [GAP_WIDTH-1:0] violation_count
);

  localparam logic [GAP_WIDTH-1:0] SAT = GAP_WIDTH'(gap_sat(GAP_WIDTH));

  logic                 pulse_reg, pulse_next;
  logic [GAP_WIDTH-1:0] last_reg, last_next;
  logic [GAP_WIDTH-1:0] min_reg, min_next;
  logic [GAP_WIDTH-1:0] count_reg, count_next;

  always_comb begin
    pulse_next = update && viol;
    last_next  = last_reg;
    min_next   = min_reg;
    count_next = count_reg;
    // A clear outranks a coincident update; the violation pulse is kept regardless.
    if (clear) begin
      last_next  = '0;
      min_next   = SAT;
      count_next = '0;
    end else if (update) begin
      last_next = gap;
      if (gap < min_reg) begin
        min_next = gap;
      end
      if (viol && (count_reg != SAT)) begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      pulse_reg <= 1'b0;
      last_reg  <= '0;
      min_reg   <= SAT;
      count_reg <= '0;
    end else begin
      pulse_reg <= pulse_next;
      last_reg  <= last_next;
      min_reg   <= min_next;
      count_reg <= count_next;
    end
  end

  assign gap_violation   = pulse_reg;
  assign last_gap        = last_reg;
  assign min_gap         = min_reg;
  assign violation_count = count_reg;

endmodule

// File: rtl/axis_gap_checker.sv
// AXI-Stream pass-through that measures idle cycles between packets and flags or drops
// packets that start too soon after the previous packet's last beat.
module axis_gap_checker
  import axis_gap_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int MIN_GAP_CYCLES = 1,
  parameter int GAP_WIDTH      = 16,
  parameter int DROP_VIOLATORS = 0
) (
  input  logic                      clk,
  input  logic                      sreset,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]     axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_BYTES-1:0]     axis_o_tkeep,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  input  logic                      stats_clear,
  output logic                      gap_violation,
  output logic [GAP_WIDTH-1:0]      last_gap,
  output logic [GAP_WIDTH-1:0]      min_gap,
  output logic [GAP_WIDTH-1:0]      violation_count
);

  localparam logic [GAP_WIDTH-1:0] SAT     = GAP_WIDTH'(gap_sat(GAP_WIDTH));
  localparam bit                   DROP_EN = (DROP_VIOLATORS != 0);

  gap_state_e           state_reg, state_next;
  logic [GAP_WIDTH-1:0] ctr_reg, ctr_next;
  logic                 violation;
  logic                 drop_beat;
  logic                 accept;
  logic                 in_ready;
  logic                 out_valid;
  logic                 stats_update;

  assign axis_o_tlast  = axis_i_tlast;
  assign axis_o_tkeep  = axis_i_tkeep;
  assign axis_o_tdata  = axis_i_tdata;
  assign axis_o_tuser  = axis_i_tuser;
  assign axis_i_tready = in_ready;
  assign axis_o_tvalid = out_valid;

  // A zero minimum can never be undercut, so the comparison is left out entirely.
  if (MIN_GAP_CYCLES == 0) begin : g_min_zero
    assign violation = 1'b0;
  end else begin : g_min_check
    localparam logic [GAP_WIDTH-1:0] MIN_W = GAP_WIDTH'(MIN_GAP_CYCLES);
    assign violation = (state_reg == ST_GAP) && (ctr_reg < MIN_W);
  end

  always_comb begin
    state_next   = state_reg;
    ctr_next     = ctr_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    stats_update = 1'b0;
    drop_beat    = (state_reg == ST_DROP) || (DROP_EN && violation);
    accept       = 1'b0;
    if (sreset) begin
      state_next = ST_START;
      ctr_next   = '0;
    end else begin
      in_ready  = drop_beat ? 1'b1 : axis_o_tready;
      out_valid = drop_beat ? 1'b0 : axis_i_tvalid;
      accept    = axis_i_tvalid && in_ready;
      case (state_reg)
        ST_START: begin
          if (accept) begin
            if (axis_i_tlast) begin
              state_next = ST_GAP;
              ctr_next   = '0;
            end else begin
              state_next = ST_PKT;
            end
          end
        end
        ST_GAP: begin
          // Idle time is counted regardless of handshake activity.
          ctr_next = (ctr_reg == SAT) ? SAT : ctr_reg + 1'b1;
          if (accept) begin
            stats_update = 1'b1;
            if (axis_i_tlast) begin
              ctr_next = '0;
            end else begin
              state_next = drop_beat ? ST_DROP : ST_PKT;
            end
          end
        end
        ST_PKT, ST_DROP: begin
          if (accept && axis_i_tlast) begin
            state_next = ST_GAP;
            ctr_next   = '0;
          end
        end
        default: state_next = ST_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_reg <= ST_START;
      ctr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ctr_reg   <= ctr_next;
    end
  end

  axis_gap_stats #(
    .GAP_WIDTH(GAP_WIDTH)
  ) u_stats (
    .clk            (clk),
    .sreset         (sreset),
    .update         (stats_update),
    .gap            (ctr_reg),
    .viol           (violation),
    .clear          (stats_clear),
    .gap_violation  (gap_violation),
    .last_gap       (last_gap),
    .min_gap        (min_gap),
    .violation_count(violation_count)
  );

endmodule

// File: tb/tb_axis_gap_checker.sv
// Randomised scoreboard bench: lane 0 runs flag mode, lane 1 drop mode, each against a
// timestamp-based reference model of the gap rules.
module tb_axis_gap_checker;

  localparam int BYTES = 2;
  localparam int UB    = 2;
  localparam int MINC  = 2;
  localparam int GW    = 4;
  localparam int SAT   = 15;
  localparam int NCYC  = 3000;

  typedef struct packed {
    logic             last;
    logic [BYTES-1:0] keep;
    logic [8*BYTES-1:0] data;
    logic [UB-1:0]    user;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done [2];

  task automatic chk(input string name, input int lane, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane%0d t=%0t: got %0h want %0h", name, lane, $time, act, exp);
    end
  endtask

  function automatic int pick_idle();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return r;
    if (r <= 7) return 0;
    if (r == 8) return $urandom_range(14, 18);
    return 2;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic               sreset, stats_clear, gap_violation;
    logic               i_tready, i_tvalid, i_tlast, o_tready, o_tvalid, o_tlast;
    logic [BYTES-1:0]   i_tkeep, o_tkeep;
    logic [8*BYTES-1:0] i_tdata, o_tdata;
    logic [UB-1:0]      i_tuser, o_tuser;
    logic [GW-1:0]      last_gap, min_gap, violation_count;
    beat_t              q[$];
    int                 pkts_seen = 0;

    axis_gap_checker #(
      .AXIS_BYTES(BYTES), .AXIS_USER_BITS(UB), .MIN_GAP_CYCLES(MINC),
      .GAP_WIDTH(GW), .DROP_VIOLATORS(gi)
    ) dut (
      .clk(clk), .sreset(sreset),
      .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast),
      .axis_i_tkeep(i_tkeep), .axis_i_tdata(i_tdata), .axis_i_tuser(i_tuser),
      .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid), .axis_o_tlast(o_tlast),
      .axis_o_tkeep(o_tkeep), .axis_o_tdata(o_tdata), .axis_o_tuser(o_tuser),
      .stats_clear(stats_clear), .gap_violation(gap_violation), .last_gap(last_gap),
      .min_gap(min_gap), .violation_count(violation_count)
    );

    // Monitor: every delivered beat must match the oldest expected beat.
    always @(negedge clk) begin
      beat_t e;
      if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
        if (q.size() == 0) begin
          chk("extra_beat", gi, 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("beat", gi, 64'({o_tlast, o_tkeep, o_tdata, o_tuser}), 64'(e));
          if (o_tlast) begin
            pkts_seen++;
            $display("lane%0d packet %0d delivered, last_gap=%0d", gi, pkts_seen, last_gap);
          end
        end
      end
    end

    // Driver plus reference model: gaps come from timestamps of tlast accepts.
    initial begin
      int rst_left, idle_left, beats_left, m_last_t, cyc, gap;
      int e_last, e_min, e_cnt;
      bit holding, newbeat, m_started, m_in_pkt, m_drop, e_pulse;
      bit first, viol, drop_now, exp_rdy, exp_ov, acc, upd;
      beat_t b;
      rst_left = 3; idle_left = 0; beats_left = 0; m_last_t = 0; cyc = 0; gap = 0;
      e_last = 0; e_min = SAT; e_cnt = 0; e_pulse = 0;
      holding = 0; m_started = 0; m_in_pkt = 0; m_drop = 0;
      sreset = 1'b1; stats_clear = 1'b0; o_tready = 1'b0;
      i_tvalid = 1'b0; i_tlast = 1'b0; i_tkeep = '0; i_tdata = '0; i_tuser = '0;
      @(posedge clk);
      #1;
      while (cyc < NCYC || holding || beats_left > 0) begin
        if (cyc >= NCYC + 400) begin
          chk("drain_timeout", gi, 64'(cyc), 64'(NCYC));
          break;
        end
        newbeat = 0;
        if (rst_left == 0 && cyc < NCYC && $urandom_range(0, 199) == 0) begin
          rst_left = $urandom_range(1, 2);
          holding = 0; beats_left = 0; idle_left = 0;
          q.delete();
        end
        stats_clear = ($urandom_range(0, 15) == 0);
        o_tready = ($urandom_range(0, 3) != 0);
        if (rst_left > 0) begin
          sreset = 1'b1; i_tvalid = 1'b0; rst_left--;
        end else begin
          sreset = 1'b0;
          if (!holding) begin
            if (idle_left > 0) begin
              i_tvalid = 1'b0; idle_left--;
            end else if (cyc < NCYC || beats_left > 0) begin
              if (beats_left == 0) beats_left = $urandom_range(1, 4);
              i_tdata = 16'($urandom); i_tkeep = 2'($urandom); i_tuser = 2'($urandom);
              i_tlast = (beats_left == 1); i_tvalid = 1'b1;
              holding = 1; newbeat = 1;
            end else begin
              i_tvalid = 1'b0;
            end
          end
        end

        first = !m_in_pkt;
        gap = (cyc - m_last_t - 1 > SAT) ? SAT : cyc - m_last_t - 1;
        viol = m_started && first && (gap < MINC);
        drop_now = m_in_pkt ? m_drop : (gi == 1 && viol);
        exp_rdy = sreset ? 1'b0 : (drop_now ? 1'b1 : o_tready);
        exp_ov = sreset ? 1'b0 : (drop_now ? 1'b0 : i_tvalid);
        if (newbeat && !drop_now) begin
          b = {i_tlast, i_tkeep, i_tdata, i_tuser};
          q.push_back(b);
        end

        @(negedge clk);
        chk("i_tready", gi, 64'(i_tready), 64'(exp_rdy));
        chk("o_tvalid", gi, 64'(o_tvalid), 64'(exp_ov));
        chk("gap_violation", gi, 64'(gap_violation), 64'(e_pulse));
        chk("last_gap", gi, 64'(last_gap), 64'(e_last));
        chk("min_gap", gi, 64'(min_gap), 64'(e_min));
        chk("violation_count", gi, 64'(violation_count), 64'(e_cnt));

        @(posedge clk);
        acc = i_tvalid && exp_rdy;
        if (sreset) begin
          e_pulse = 0; e_last = 0; e_min = SAT; e_cnt = 0;
          m_started = 0; m_in_pkt = 0; m_drop = 0;
        end else begin
          e_pulse = acc && first && viol;
          upd = acc && first && m_started;
          if (stats_clear) begin
            e_last = 0; e_min = SAT; e_cnt = 0;
          end else if (upd) begin
            e_last = gap;
            if (gap < e_min) e_min = gap;
            if (viol && e_cnt < SAT) e_cnt++;
          end
          if (acc) begin
            if (first) begin
              m_started = 1; m_drop = drop_now;
            end
            if (i_tlast) begin
              m_in_pkt = 0; m_last_t = cyc;
            end else begin
              m_in_pkt = 1;
            end
          end
        end
        if (acc) begin
          holding = 0;
          beats_left--;
          idle_left = (beats_left == 0) ? pick_idle() : (($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        cyc++;
        #1;
      end
      i_tvalid = 1'b0;
      @(negedge clk);
      chk("queue_empty", gi, 64'(q.size()), 64'(0));
      done[gi] = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < NCYC + 2000 && !(done[0] && done[1]); k++) @(posedge clk);
    if (!(done[0] && done[1])) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: lanes done %0d/%0d, required 1/1", done[0], done[1]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_gap_checker.md
Name: axis_gap_checker

Overview:
- AXI-Stream pass-through that measures the idle gap between consecutive packets.
- Flags packets that arrive with fewer than MIN_GAP_CYCLES idle cycles since the previous packet's last beat.
- Optionally drops violating packets whole.
- Receive-side counterpart of the packet spacer: placed downstream of a spacer or at link ingress to police inter-packet spacing. Also keeps gap statistics for debug registers.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes; tkeep width.
- AXIS_USER_BITS, 1, tuser width.
- MIN_GAP_CYCLES, 1, minimum legal idle cycles between packets, range 0..2^GAP_WIDTH-1.
- GAP_WIDTH, 16, width of the gap counter and statistics; all counting saturates.
- DROP_VIOLATORS, 0, 1 = discard violating packets, 0 = flag only.

Ports:
- clk  in  1  clock
- sreset  in  1  synchronous reset, active-high
- axis_i_tready/tvalid/tlast/tkeep/tdata/tuser  slave AXIS, widths 1/1/1/AXIS_BYTES/8*AXIS_BYTES/AXIS_USER_BITS
- axis_o_tready/tvalid/tlast/tkeep/tdata/tuser  master AXIS, same widths
- stats_clear  in  1  single-cycle clear of statistics
- gap_violation  out  1  one-cycle pulse on acceptance of a violating first beat
- last_gap  out  GAP_WIDTH  gap measured at the most recent packet start
- min_gap  out  GAP_WIDTH  smallest gap seen since reset or clear; all-ones if none
- violation_count  out  GAP_WIDTH  saturating count of violating packets

Behaviour:
- Single clock domain. sreset is synchronous and active-high.
- Accept means axis_i_tvalid && axis_i_tready in the same cycle.
- Datapath is combinational and zero-latency:
  - tdata, tkeep, tuser and tlast are wired straight through.
  - Only tvalid and tready are gated.
- States:
  - START: no packet seen since reset. Pass-through. Accepting a first beat goes to PKT, or to GAP if that beat has tlast. No gap is measured and there is no violation.
  - GAP: counting idle cycles. ctr increments every cycle and saturates at all-ones. The counter ignores tvalid and tready.
  - PKT: mid-packet, pass-through. Accepting a tlast beat sets ctr to 0 and goes to GAP.
  - DROP: mid-packet, discarding. axis_i_tready=1 and axis_o_tvalid=0. Accepting a tlast beat sets ctr to 0 and goes to GAP.
- Gap definition:
  - tlast accepted in cycle t gives ctr=0 in cycle t+1.
  - A first beat accepted in cycle t+1+N has measured gap N.
  - Back-to-back packets measure 0.
- Violation is a combinational condition, true when state is GAP and ctr < MIN_GAP_CYCLES.
  - MIN_GAP_CYCLES=0 never violates.
- First beat in GAP, DROP_VIOLATORS=0 or no violation:
  - Pass-through: axis_i_tready=axis_o_tready and axis_o_tvalid=axis_i_tvalid.
  - On accept, go to PKT, or stay in GAP with ctr=0 if the beat has tlast.
- First beat in GAP, DROP_VIOLATORS=1 and violation:
  - axis_i_tready=1 and axis_o_tvalid=0, so the beat is accepted and discarded.
  - Go to DROP, or stay in GAP with ctr=0 if the beat has tlast.
- On every first-beat accept in GAP, registered in the next cycle:
  - last_gap <= ctr.
  - min_gap <= min(min_gap, ctr).
  - If violating: gap_violation=1 for exactly one cycle, and violation_count increments, saturating.
- stats_clear:
  - Sets last_gap=0, min_gap=all-ones, violation_count=0 in the next cycle.
  - If an update coincides with a clear, the clear wins and that update is lost.
  - gap_violation still pulses.
  - Does not affect state or ctr.
- While sreset is high:
  - axis_i_tready=0 and axis_o_tvalid=0.
  - Next state is START, ctr=0, gap_violation=0, last_gap=0, min_gap=all-ones, violation_count=0.
- Reset mid-packet abandons the packet. The downstream sees a truncated packet; this is the caller's concern.
- Gap saturation: gaps at or above 2^GAP_WIDTH-1 read as all-ones and never violate.

Decomposition:
- Package axis_gap_pkg:
  - state enum {START, GAP, PKT, DROP}.
  - GAP_SAT constant: all-ones of GAP_WIDTH, as a function or parameterised constant.
- One sub-module, axis_gap_stats:
  - Holds last_gap, min_gap and violation_count.
  - Inputs: update strobe, gap value, violation flag, clear.
- FSM and ctr stay in the top.

Test Plan:
- MIN=2, flag mode. Packets of 3 beats; idle cycles after the tlast accept: 0, 1, 2, 5 → violation pulses for the 2nd and 3rd packets (gaps 0 and 1). last_gap sequence 0,1,2,5; min_gap=0; violation_count=2. All beats appear on the output unmodified.
- MIN=2, drop mode. Same stimulus → output carries packets 1, 4 and 5 only. Dropped beats are accepted with tready=1 while axis_o_tvalid stays 0. violation_count=2.
- Downstream backpressure: axis_o_tready=0 for 4 cycles while a first beat is presented 1 cycle after tlast, MIN=3 → accept occurs at gap 4, no violation. The counter keeps running during the stall.
- Single-beat packets (tlast on the first beat) back-to-back, MIN=1, drop mode → every packet after the first is dropped. State stays in GAP with ctr=0 each time.
- stats_clear asserted in the same cycle as the first-beat accept of a violating packet → gap_violation pulses. Counters read 0, 0 and all-ones afterwards.
- sreset asserted mid-packet, then a new packet after 0 idle cycles → no violation (START), and the stats are at reset values.
